// File: rtl/shift_8x64_tap_inject.sv
`default_nettype none
// ============================================================================
// Module   : shift_8x64_tap_inject
// Purpose  : 64-stage x 8-bit delay line with a valid bit per stage.
//            Stages 15, 31 and 47 can be read and also overwritten.
//            Overwriting a stage splices a byte into the line mid-flight.
//            Optional occupancy counter is enabled by the macro
//            SR_OCCUPANCY_EN, which adds the occ_count port.
// Revision : 1.0 - initial release
// ============================================================================
module shift_8x64_tap_inject (
   input  logic       clk,
   input  logic       rst,
   input  logic       shift,
   input  logic [7:0] sr_in,
   input  logic       sr_in_valid,
   input  logic [2:0] inj_en,
   input  logic [7:0] inj_data_one,
   input  logic [7:0] inj_data_two,
   input  logic [7:0] inj_data_three,
   output logic [7:0] sr_out,
   output logic       sr_out_valid,
   output logic [7:0] sr_tap_one,
   output logic [7:0] sr_tap_two,
   output logic [7:0] sr_tap_three
`ifdef SR_OCCUPANCY_EN
   ,
   output logic [6:0] occ_count
`endif
);

   localparam int c_TAP_ONE   = 15;
   localparam int c_TAP_TWO   = 31;
   localparam int c_TAP_THREE = 47;

   // Stage storage: index 0 is the input end, index 63 the output end.
   logic [63:0][7:0] d_q, d_d;
   logic [63:0]      v_q, v_d;

   // Next state: shift or hold first, then tap writes override their stage.
   // Overriding after the shift means the byte moving into a written tap is
   // lost, while the byte that was already in the tap still moves onward.
   always_comb begin
      d_d = d_q;
      v_d = v_q;
      if (shift) begin
         d_d = {d_q[62:0], sr_in};
         v_d = {v_q[62:0], sr_in_valid};
      end
      if (inj_en[0]) begin
         d_d[c_TAP_ONE] = inj_data_one;
         v_d[c_TAP_ONE] = 1'b1;
      end
      if (inj_en[1]) begin
         d_d[c_TAP_TWO] = inj_data_two;
         v_d[c_TAP_TWO] = 1'b1;
      end
      if (inj_en[2]) begin
         d_d[c_TAP_THREE] = inj_data_three;
         v_d[c_TAP_THREE] = 1'b1;
      end
   end

   // Line registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_q <= '0;
         v_q <= '0;
      end else begin
         d_q <= d_d;
         v_q <= v_d;
      end
   end

   assign sr_out       = d_q[63];
   assign sr_out_valid = v_q[63];
   assign sr_tap_one   = d_q[c_TAP_ONE];
   assign sr_tap_two   = d_q[c_TAP_TWO];
   assign sr_tap_three = d_q[c_TAP_THREE];

`ifdef SR_OCCUPANCY_EN
   logic [6:0] occ_q, occ_d;
   logic [6:0] w_vshift;
   logic [1:0] w_inj_new_cnt;

   // Incremental count: a tap write only adds when the stage it lands on
   // would otherwise hold an invalid byte after this cycle's shift/hold.
   always_comb begin
      w_vshift      = {6'd0, 1'b0};
      w_inj_new_cnt = 2'd0;
      if (inj_en[0] && !(shift ? v_q[c_TAP_ONE-1] : v_q[c_TAP_ONE]))
         w_inj_new_cnt = w_inj_new_cnt + 2'd1;
      if (inj_en[1] && !(shift ? v_q[c_TAP_TWO-1] : v_q[c_TAP_TWO]))
         w_inj_new_cnt = w_inj_new_cnt + 2'd1;
      if (inj_en[2] && !(shift ? v_q[c_TAP_THREE-1] : v_q[c_TAP_THREE]))
         w_inj_new_cnt = w_inj_new_cnt + 2'd1;
      w_vshift = {6'd0, shift & sr_in_valid};
      occ_d    = occ_q + w_vshift - {6'd0, shift & v_q[63]} + {5'd0, w_inj_new_cnt};
   end

   // Occupancy register, cleared with the line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) occ_q <= 7'd0;
      else     occ_q <= occ_d;
   end

   assign occ_count = occ_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_8x64_tap_inject.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_8x64_tap_inject
// Purpose  : Directed plus randomized bench for shift_8x64_tap_inject with
//            a queue-based reference of the 64-byte line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_8x64_tap_inject;

   logic       clk = 1'b0;
   logic       rst;
   logic       shift;
   logic [7:0] sr_in;
   logic       sr_in_valid;
   logic [2:0] inj_en;
   logic [7:0] inj_data_one, inj_data_two, inj_data_three;
   logic [7:0] sr_out;
   logic       sr_out_valid;
   logic [7:0] sr_tap_one, sr_tap_two, sr_tap_three;
`ifdef SR_OCCUPANCY_EN
   logic [6:0] occ_count;
`endif

   always #5 clk = ~clk;

   shift_8x64_tap_inject dut (
      .clk            (clk),
      .rst            (rst),
      .shift          (shift),
      .sr_in          (sr_in),
      .sr_in_valid    (sr_in_valid),
      .inj_en         (inj_en),
      .inj_data_one   (inj_data_one),
      .inj_data_two   (inj_data_two),
      .inj_data_three (inj_data_three),
      .sr_out         (sr_out),
      .sr_out_valid   (sr_out_valid),
      .sr_tap_one     (sr_tap_one),
      .sr_tap_two     (sr_tap_two),
      .sr_tap_three   (sr_tap_three)
`ifdef SR_OCCUPANCY_EN
      ,
      .occ_count      (occ_count)
`endif
   );

   int checks = 0;
   int passes = 0;

   // Reference line: element 0 is the input end, element 63 the output end.
   byte unsigned qd[$];
   bit           qv[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      qd.delete();
      qv.delete();
      repeat (64) begin
         qd.push_back(8'h00);
         qv.push_back(1'b0);
      end
   endtask

   function automatic int model_occ();
      int n = 0;
      foreach (qv[i]) n += int'(qv[i]);
      return n;
   endfunction

   task automatic model_step(input bit sh, input byte unsigned din, input bit dv,
                             input logic [2:0] en, input byte unsigned a,
                             input byte unsigned b, input byte unsigned c);
      if (sh) begin
         void'(qd.pop_back());
         void'(qv.pop_back());
         qd.push_front(din);
         qv.push_front(dv);
      end
      if (en[0]) begin qd[15] = a; qv[15] = 1'b1; end
      if (en[1]) begin qd[31] = b; qv[31] = 1'b1; end
      if (en[2]) begin qd[47] = c; qv[47] = 1'b1; end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out"},    sr_out,       qd[63]);
      chk({tag, ".outv"},   sr_out_valid, qv[63]);
      chk({tag, ".tap1"},   sr_tap_one,   qd[15]);
      chk({tag, ".tap2"},   sr_tap_two,   qd[31]);
      chk({tag, ".tap3"},   sr_tap_three, qd[47]);
`ifdef SR_OCCUPANCY_EN
      chk({tag, ".occ"},    occ_count,    model_occ());
`endif
   endtask

   // One clock: drive, let the edge happen, advance the model, check 1ns later.
   task automatic cyc(input string tag, input bit sh, input byte unsigned din, input bit dv,
                      input logic [2:0] en, input byte unsigned a,
                      input byte unsigned b, input byte unsigned c);
      shift = sh; sr_in = din; sr_in_valid = dv;
      inj_en = en; inj_data_one = a; inj_data_two = b; inj_data_three = c;
      @(posedge clk);
      model_step(sh, din, dv, en, a, b, c);
      #1;
      check_all(tag);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      byte unsigned old15;
      rst = 1'b1; shift = 1'b0; sr_in = 8'h00; sr_in_valid = 1'b0;
      inj_en = 3'b000; inj_data_one = 8'h00; inj_data_two = 8'h00; inj_data_three = 8'h00;
      model_reset();
      #12;
      check_all("reset");
      rst = 1'b0;

      // Fill and drain
      for (int i = 0; i < 64; i++) cyc("fill", 1'b1, 8'(i), 1'b1, 3'b000, 0, 0, 0);
      chk("fill_out",  sr_out,       8'h00);
      chk("fill_outv", sr_out_valid, 1'b1);
      chk("fill_tap1", sr_tap_one,   8'h30);
      chk("fill_tap2", sr_tap_two,   8'h20);
      chk("fill_tap3", sr_tap_three, 8'h10);
`ifdef SR_OCCUPANCY_EN
      chk("fill_occ",  occ_count,    7'd64);
`endif

      // Collision: shift and tap-one write in the same cycle on a full line
      cyc("coll_pre", 1'b1, 8'h11, 1'b1, 3'b000, 0, 0, 0);
      old15 = qd[15];
      cyc("coll", 1'b1, 8'h11, 1'b1, 3'b001, 8'h5A, 0, 0);
      chk("coll_tap1", sr_tap_one, 8'h5A);
`ifdef SR_OCCUPANCY_EN
      chk("coll_occ",  occ_count,  7'd64);
`endif
      for (int i = 0; i < 15; i++) cyc("coll_run", 1'b1, 8'h11, 1'b1, 3'b000, 0, 0, 0);
      chk("coll_moved", sr_tap_two, old15);

      // Inject without shift on an empty line
      pulse_reset();
      cyc("inj2", 1'b0, 8'h00, 1'b0, 3'b010, 0, 8'hA5, 0);
      chk("inj2_tap2", sr_tap_two, 8'hA5);
`ifdef SR_OCCUPANCY_EN
      chk("inj2_occ",  occ_count,  7'd1);
`endif
      for (int i = 0; i < 32; i++) cyc("inj2_run", 1'b1, 8'($urandom), 1'b0, 3'b000, 0, 0, 0);
      chk("inj2_out",  sr_out,       8'hA5);
      chk("inj2_outv", sr_out_valid, 1'b1);

      // Triple inject then stall
      pulse_reset();
      cyc("inj3", 1'b0, 8'h00, 1'b0, 3'b111, 8'h01, 8'h02, 8'h03);
      for (int i = 0; i < 10; i++) begin
         cyc("stall", 1'b0, 8'($urandom), 1'($urandom), 3'b000, 8'($urandom), 8'($urandom), 8'($urandom));
         chk("stall_tap1", sr_tap_one,   8'h01);
         chk("stall_tap2", sr_tap_two,   8'h02);
         chk("stall_tap3", sr_tap_three, 8'h03);
`ifdef SR_OCCUPANCY_EN
         chk("stall_occ",  occ_count,    7'd3);
`endif
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [2:0] en;
         en = (($urandom % 6) == 0) ? 3'($urandom) : 3'b000;
         cyc("rand", ($urandom % 4) != 0, 8'($urandom), 1'($urandom), en,
             8'($urandom), 8'($urandom), 8'($urandom));
      end

      // Asynchronous reset between edges while streaming
      for (int i = 0; i < 5; i++) cyc("pre_rst", 1'b1, 8'($urandom), 1'b1, 3'b000, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out",  sr_out,       8'h00);
      chk("arst_outv", sr_out_valid, 1'b0);
      chk("arst_tap1", sr_tap_one,   8'h00);
      chk("arst_tap2", sr_tap_two,   8'h00);
      chk("arst_tap3", sr_tap_three, 8'h00);
`ifdef SR_OCCUPANCY_EN
      chk("arst_occ",  occ_count,    7'd0);
`endif
      rst = 1'b0;
      model_reset();
      cyc("post_rst", 1'b1, 8'h7E, 1'b1, 3'b000, 0, 0, 0);
      for (int i = 0; i < 15; i++) cyc("post_rst", 1'b1, 8'($urandom), 1'b1, 3'b000, 0, 0, 0);
      chk("post_rst_tap1", sr_tap_one, 8'h7E);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
